// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, key colour and fetch state type
package sprite_pkg;

    typedef logic [23:0] rgb_t;

    localparam int   SPR_W     = 40;
    localparam int   SPR_H     = 40;
    localparam int   COL_W     = $clog2(SPR_W);
    localparam rgb_t KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        READY
    } fetch_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// rtl/sprite_line_buf.sv - one sprite row of pixels, sync write, comb read
module sprite_line_buf
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPR_W,
    parameter int WIDTH = $bits(rgb_t),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read indices beyond the row are never used for display; return 0 to stay defined.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/sprite_row_fetch.sv
// rtl/sprite_row_fetch.sv - fetches one sprite row per scanline and serves keyed pixels
module sprite_row_fetch
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        LineY,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic [9:0]        DrawX,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_rgb
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPR_W - 1);

    fetch_state_t       state, state_next;
    logic               hit;
    logic [9:0]         sx;
    logic [ADDR_W-1:0]  base;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_d1;
    logic               wv;

    logic signed [10:0] dy;
    logic signed [10:0] dx;
    logic               hit_next;
    logic [ADDR_W-1:0]  dy_ext;
    logic [ADDR_W-1:0]  base_next;
    logic [DATA_W-1:0]  rdata;
    logic               buf_we;

    always_comb begin
        dy        = $signed({1'b0, LineY}) - $signed({1'b0, SprY});
        hit_next  = !dy[10] && (dy[9:0] <= 10'(SPR_H - 1));
        dy_ext    = ADDR_W'(dy[COL_W-1:0]);
        base_next = ADDR_W'(dy_ext * ADDR_W'(SPR_W));
        dx        = $signed({1'b0, DrawX}) - $signed({1'b0, sx});
        buf_we    = wv && !line_start;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            FETCH: begin
                busy = 1'b1;
                if (col == LAST_COL) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = READY;
            end
            default: ;
        endcase
        // A new line request overrides whatever is in flight.
        if (line_start) begin
            state_next = hit_next ? FETCH : IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit      <= 1'b0;
            sx       <= '0;
            base     <= '0;
            col      <= '0;
            col_d1   <= '0;
            wv       <= 1'b0;
            rom_addr <= '0;
        end else begin
            wv     <= (state == FETCH) && !line_start;
            col_d1 <= col;
            if (line_start) begin
                hit <= hit_next;
                sx  <= SprX;
                if (hit_next) begin
                    base     <= base_next;
                    col      <= '0;
                    rom_addr <= base_next;
                end
            end else if (state == FETCH) begin
                col <= col + 1'b1;
                if (col != LAST_COL) begin
                    rom_addr <= base + ADDR_W'(col) + ADDR_W'(1);
                end
            end
        end
    end

    sprite_line_buf #(
        .DEPTH (SPR_W),
        .WIDTH (DATA_W),
        .AW    (COL_W)
    ) u_line_buf (
        .clk   (Clk),
        .we    (buf_we),
        .waddr (col_d1),
        .wdata (rom_data),
        .raddr (dx[COL_W-1:0]),
        .rdata (rdata)
    );

    // Registered pixel path; a restart request blanks output from the next cycle on.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end else if (line_start || state != READY || !hit) begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end else if (!dx[10] && (dx[9:0] < 10'(SPR_W)) && (rdata != DATA_W'(KEY_COLOR))) begin
            pix_valid <= 1'b1;
            pix_rgb   <= rdata;
        end else begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end
    end

endmodule

// File: doc/sprite_row_fetch.md
Name: sprite_row_fetch

Overview:
- Read-side client of a sprite frame ROM holding a 40x40 note sprite, 24-bit RGB, 1600 words.
- The ROM has a 1-cycle registered read: address in at edge N, data out after edge N+1.
- Once per scanline, during horizontal blanking, the block fetches the sprite row that intersects the upcoming line into a local line buffer.
- During active video it supplies per-pixel colour and valid to the colour mapper, with transparency keying.

Parameters:
- SPR_W, 40, sprite width in pixels.
- SPR_H, 40, sprite height in rows.
- ADDR_W, 13, ROM address width.
- DATA_W, 24, ROM word / pixel RGB width.
- KEY_COLOR, 24'hFF00FF, transparent colour; never reported valid.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  single-cycle pulse in hblank requesting fetch for LineY.
- LineY  in  10  scanline about to be drawn; sampled on line_start.
- SprX  in  10  sprite left edge, screen coords; sampled on line_start.
- SprY  in  10  sprite top edge; sampled on line_start.
- DrawX  in  10  current pixel column during active video.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W  ROM read data, valid 1 cycle after rom_addr.
- busy  out  1  high while a fetch is in progress.
- pix_valid  out  1  current pixel is an opaque sprite pixel.
- pix_rgb  out  DATA_W  sprite colour; 0 when pix_valid=0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; hit=0; rom_addr=0; busy=0; pix_valid=0; pix_rgb=0. Buffer contents need not reset.
- FSM states: IDLE, FETCH, DRAIN, READY.
- Row computation on line_start, from any state:
  - dy = LineY - SprY, computed 11-bit signed.
  - hit = (0 <= dy <= SPR_H-1).
  - SprX is latched as sx.
- line_start with hit=0: go to IDLE. No ROM access; busy stays 0; pix_valid stays 0 for the whole line.
- line_start with hit=1:
  - Go to FETCH with col=0 and base=dy*SPR_W. Base is computed by multiply or shift-add; max base is 1560.
  - FETCH: rom_addr=base+col, col increments each cycle. After col=SPR_W-1 is issued, go to DRAIN.
  - Every cycle in FETCH (except the first) and in DRAIN: write rom_data to buf[col_d1], where col_d1 is col delayed one cycle with a write-valid bit.
  - DRAIN: captures the last word, then go to READY.
- Timing: busy is high from the cycle after line_start through the DRAIN cycle, i.e. exactly SPR_W+1 = 41 cycles. READY is entered 42 edges after line_start.
- rom_addr holds its last value outside FETCH. A value of 0 is also acceptable; the bench must not check rom_addr outside FETCH.
- Pixel output, registered, 1-cycle latency from DrawX:
  - Only in READY with hit=1.
  - dx = DrawX - sx, 11-bit signed.
  - If 0 <= dx <= SPR_W-1 and buf[dx] != KEY_COLOR, then pix_valid=1 and pix_rgb=buf[dx]; otherwise both 0.
  - Sprite partially off-screen right (sx > 600) is legal; only in-range columns show.
- line_start during FETCH/DRAIN aborts the current fetch and restarts with the new parameters. Pending write-valid from the old fetch is discarded. pix_valid is 0 until the new READY.
- line_start in READY restarts the fetch; pix_valid drops the cycle after line_start.
- Reset mid-fetch: immediate IDLE; all outputs return to reset values.
- DrawX is ignored outside READY; outputs stay 0.

Decomposition:
- Shared package sprite_pkg holds:
  - SPR_W, SPR_H, KEY_COLOR;
  - the state enum typedef fetch_state_t;
  - rgb_t (logic [23:0]).
- Sub-module sprite_line_buf: SPR_W x DATA_W register array, one synchronous write port (we, waddr, wdata), one combinational read port (raddr, rdata). It has no reset.

Test Plan:
- Reset: assert Reset_n=0 mid-run -> busy=0, pix_valid=0, pix_rgb=0, state IDLE within the same cycle (async).
- Hit fetch: SprY=100, LineY=103, SprX=200, ROM model with mem[i]=i -> rom_addr 120..159 on 40 consecutive cycles, busy high 41 cycles, buf[c]=120+c.
- Miss: SprY=100, LineY=140 (and LineY=99) -> no rom_addr change, busy never high, pix_valid=0 for DrawX 0..639.
- Pixel output after the hit fetch:
  - DrawX=205 -> next cycle pix_valid=1, pix_rgb=125.
  - DrawX=199 and DrawX=240 -> pix_valid=0.
  - mem[125] set to 24'hFF00FF -> pix_valid=0 at DrawX=205.
- Abort: second line_start with LineY=110 on the 10th FETCH cycle -> addresses restart at 400..439, buf[c]=400+c for all c, READY 42 edges after the second pulse.
- Right-edge clip: SprX=620, hit row -> DrawX 620..639 valid with buf[0..19]; nothing wraps to DrawX 0..19.
